mc_mips_core: RTL and testbench

Parametrised multicycle successor to the single-cycle MIPS datapath. It shares one memory port between instruction fetch and data access, and uses a req/gnt/rvalid handshake so the port tolerates arbitrary memory wait states. A control FSM sequences fetch, decode, execute, memory and writeback. The core sits between the system bus arbiter and a unified instruction/data RAM.

---
 rtl/mc_mips_pkg.sv | 66 ++++++
 rtl/mc_regfile.sv | 28 ++
 rtl/mc_mips_core.sv | 213 +++++++++++++++++++++
 tb/tb_mc_mips_core.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_mips_pkg.sv
// Shared opcode/funct encodings, ALU and FSM enums, and decode helpers for the multicycle MIPS core.
package mc_mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_IWAIT,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_MWAIT,
        ST_WB,
        ST_TRAP
    } state_e;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                           (fn == FN_OR)  || (fn == FN_SLT);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Non-R-type instructions only ever need an add (address/immediate) or a subtract (beq).
    function automatic alu_op_e alu_decode(input logic [5:0] op, input logic [5:0] fn);
        alu_op_e res;
        res = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_SUB:  res = ALU_SUB;
                FN_AND:  res = ALU_AND;
                FN_OR:   res = ALU_OR;
                FN_SLT:  res = ALU_SLT;
                default: res = ALU_ADD;
            endcase
        end else if (op == OP_BEQ) begin
            res = ALU_SUB;
        end
        return res;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREG x XLEN register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module mc_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/mc_mips_core.sv
// Multicycle MIPS core sharing one req/gnt/rvalid memory port between fetch and data access.
module mc_mips_core
    import mc_mips_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREG     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            retire,
    output logic [XLEN-1:0] pc_out,
    output logic            trap
);

    localparam int AW         = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int ALIGN_BITS = $clog2(XLEN / 8);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic [XLEN-1:0] mdr_q, mdr_d;

    logic [5:0]      opcode, funct;
    logic [4:0]      rs, rt, rd;
    logic [15:0]     imm;
    logic [25:0]     target;
    logic [XLEN-1:0] simm;
    logic            is_rtype, is_lw, is_sw, is_beq, is_j, legal;

    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_b, alu_result;
    logic            misaligned;

    logic [XLEN-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic [AW-1:0]   rf_waddr;
    logic            rf_we;
    logic            req_int;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign target   = ir_q[25:0];
    assign simm     = {{(XLEN-16){imm[15]}}, imm};
    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign legal    = is_legal(opcode, funct);
    assign alu_op   = alu_decode(opcode, funct);
    assign alu_b    = is_rtype ? b_q : simm;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = a_q + alu_b;
            ALU_SUB: alu_result = a_q - alu_b;
            ALU_AND: alu_result = a_q & alu_b;
            ALU_OR:  alu_result = a_q | alu_b;
            ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    assign misaligned = |alu_result[ALIGN_BITS-1:0];

    assign rf_waddr = is_rtype ? AW'(rd) : AW'(rt);
    assign rf_wdata = is_lw ? mdr_q : alu_out_q;

    mc_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk     (clk),
        .raddr_a (AW'(rs)),
        .raddr_b (AW'(rt)),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        req_int   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        retire    = 1'b0;
        rf_we     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                req_int = 1'b1;
                if (mem_gnt) begin
                    state_d = ST_IWAIT;
                end
            end
            ST_IWAIT: begin
                if (mem_rvalid) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + XLEN'(4);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d = rf_rdata_a;
                b_d = rf_rdata_b;
                if (!legal) begin
                    state_d = ST_TRAP;
                end else if (is_j) begin
                    pc_d    = {pc_q[XLEN-1:28], target, 2'b00};
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_out_d = alu_result;
                if (is_beq) begin
                    if (a_q == b_q) begin
                        pc_d = pc_q + (simm << 2);
                    end
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = misaligned ? ST_TRAP : ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            // Address and write data come from registers, so they hold steady while the grant stalls.
            ST_MEM: begin
                req_int  = 1'b1;
                mem_we   = is_sw;
                mem_addr = alu_out_q;
                if (mem_gnt) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_MWAIT;
                    end
                end
            end
            ST_MWAIT: begin
                if (mem_rvalid) begin
                    mdr_d   = mem_rdata;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    // Reset is in FETCH, so the request is gated to drop the moment reset asserts.
    assign mem_req   = req_int & rst_n;
    assign mem_wdata = b_q;
    assign trap      = (state_q == ST_TRAP);
    assign pc_out    = ((state_q == ST_FETCH) || (state_q == ST_IWAIT)) ? pc_q : (pc_q - XLEN'(4));

endmodule

// File: tb/tb_mc_mips_core.sv
// Directed self-checking bench for mc_mips_core with a behavioural single-port memory model.
module tb_mc_mips_core;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h100;
    localparam logic [31:0] TRAPWORD = 32'hFC00_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mem_req, mem_we, retire, trap;
    logic [XLEN-1:0] mem_addr, mem_wdata, pc_out;
    logic            mem_gnt = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    int          gnt_stall = 0;

    int          cyc = 0;
    int          stall_cnt = 0;
    bit          in_req = 1'b0;
    bit          rd_pending = 1'b0;
    logic [31:0] rd_data = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_we = 1'b0;
    int          stab_err = 0;
    int          req_count = 0;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          retire_log [$];

    mc_mips_core #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .NREG     (32)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .retire     (retire),
        .pc_out     (pc_out),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    // Memory model: grants after gnt_stall low cycles, returns read data one cycle after the grant.
    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!rst_n) begin
            stall_cnt  = 0;
            in_req     = 1'b0;
            rd_pending = 1'b0;
            stab_err   = 0;
            req_count  = 0;
            wr_addr_q.delete();
            wr_data_q.delete();
        end else begin
            if (rd_pending) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_data;
                rd_pending = 1'b0;
            end
            if (mem_req) begin
                if (in_req) begin
                    if (mem_addr !== req_addr || mem_we !== req_we || mem_wdata !== req_wdata)
                        stab_err++;
                end else begin
                    in_req    = 1'b1;
                    req_addr  = mem_addr;
                    req_we    = mem_we;
                    req_wdata = mem_wdata;
                    req_count++;
                end
                if (stall_cnt < gnt_stall) begin
                    stall_cnt++;
                end else begin
                    mem_gnt   = 1'b1;
                    stall_cnt = 0;
                    in_req    = 1'b0;
                    if (mem_we) begin
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                    end else begin
                        rd_pending = 1'b1;
                        rd_data    = mem[mem_addr[9:2]];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst_n)      retire_log.delete();
        else if (retire) retire_log.push_back(cyc + 1);
    end

    task automatic fill_trap();
        for (int i = 0; i < 256; i++) mem[i] = TRAPWORD;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[9:2]] = word;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_trap(input int max_cycles, output bit seen, output int at_cycle);
        seen = 1'b0;
        at_cycle = -1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #2;
            if (trap === 1'b1) begin
                seen = 1'b1;
                at_cycle = cyc + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gnt_stall = 0;
        fill_trap();
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req actual=%0b required=0", mem_req); end
        checks++; if (trap !== 1'b0) begin errors++; $display("[TB] FAIL reset_trap actual=%0b required=0", trap); end
        checks++; if (retire !== 1'b0) begin errors++; $display("[TB] FAIL reset_retire actual=%0b required=0", retire); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req actual=%0b required=1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL first_addr actual=%h required=00000100", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL first_we actual=%0b required=0", mem_we); end
        checks++; if (pc_out !== 32'h100) begin errors++; $display("[TB] FAIL first_pc actual=%h required=00000100", pc_out); end
    endtask

    task automatic load_sum_program();
        fill_trap();
        put(32'h100, 32'h2001_0005);
        put(32'h104, 32'h2002_0007);
        put(32'h108, 32'h0022_1820);
        put(32'h10C, 32'hAC03_0040);
    endtask

    task automatic run_sum(input int stall, input int e0, input int e1, input int e2, input int e3);
        int  exp_ret [4];
        bit  seen;
        int  tcyc;
        int  got;
        exp_ret = '{e0, e1, e2, e3};
        gnt_stall = stall;
        load_sum_program();
        do_reset();
        wait_trap(200, seen, tcyc);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL sum_halt stall=%0d actual=no_trap required=trap", stall); end
        for (int k = 0; k < 4; k++) begin
            got = (k < retire_log.size()) ? retire_log[k] : -1;
            checks++; if (got != exp_ret[k]) begin errors++; $display("[TB] FAIL sum_retire%0d stall=%0d actual=%0d required=%0d", k, stall, got, exp_ret[k]); end
        end
        checks++; if (retire_log.size() != 4) begin errors++; $display("[TB] FAIL sum_retire_count stall=%0d actual=%0d required=4", stall, retire_log.size()); end
        checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h40 || wr_data_q[0] !== 32'd12) begin
            errors++; $display("[TB] FAIL sum_store stall=%0d actual_count=%0d required=1 write of 0000000c to 00000040", stall, wr_addr_q.size());
        end
        checks++; if (stab_err != 0) begin errors++; $display("[TB] FAIL sum_stable stall=%0d actual=%0d required=0", stall, stab_err); end
        checks++; if (req_count != 6) begin errors++; $display("[TB] FAIL sum_req_count stall=%0d actual=%0d required=6", stall, req_count); end
        checks++; if (pc_out !== 32'h110) begin errors++; $display("[TB] FAIL sum_trap_pc stall=%0d actual=%h required=00000110", stall, pc_out); end
    endtask

    task automatic test_program();
        run_sum(0, 5, 10, 15, 20);
    endtask

    task automatic test_gnt_stall();
        run_sum(3, 8, 16, 24, 35);
    endtask

    task automatic test_loop();
        bit seen;
        int tcyc;
        int last;
        gnt_stall = 0;
        fill_trap();
        put(32'h100, 32'h2001_0003);
        put(32'h104, 32'h2021_FFFF);
        put(32'h108, 32'h1020_0001);
        put(32'h10C, 32'h0800_0041);
        put(32'h110, 32'hAC01_0040);
        do_reset();
        wait_trap(300, seen, tcyc);
        last = (retire_log.size() > 0) ? retire_log[retire_log.size()-1] : -1;
        checks++; if (!seen) begin errors++; $display("[TB] FAIL loop_halt actual=no_trap required=trap"); end
        checks++; if (retire_log.size() != 10) begin errors++; $display("[TB] FAIL loop_retire_count actual=%0d required=10", retire_log.size()); end
        checks++; if (last != 43) begin errors++; $display("[TB] FAIL loop_last_retire actual=%0d required=43", last); end
        checks++; if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'd0 || wr_addr_q[0] !== 32'h40) begin
            errors++; $display("[TB] FAIL loop_r1 actual_count=%0d required=1 write of 00000000 to 00000040", wr_data_q.size());
        end
        checks++; if (pc_out !== 32'h114) begin errors++; $display("[TB] FAIL loop_final_pc actual=%h required=00000114", pc_out); end
    endtask

    task automatic test_alu_ops();
        logic [31:0] exp_d [6];
        logic [31:0] exp_a [6];
        bit seen;
        int tcyc;
        exp_d = '{32'h1, 32'hFFFF_FFF8, 32'h5, 32'hFFFF_FFFD, 32'h0, 32'h0};
        exp_a = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54};
        gnt_stall = 0;
        fill_trap();
        put(32'h100, 32'h2001_FFFD);
        put(32'h104, 32'h2002_0005);
        put(32'h108, 32'h0022_182A);
        put(32'h10C, 32'h0022_2022);
        put(32'h110, 32'h0022_2824);
        put(32'h114, 32'h0022_3025);
        put(32'h118, 32'h0022_0020);
        put(32'h11C, 32'h0041_382A);
        put(32'h120, 32'hAC03_0040);
        put(32'h124, 32'hAC04_0044);
        put(32'h128, 32'hAC05_0048);
        put(32'h12C, 32'hAC06_004C);
        put(32'h130, 32'hAC00_0050);
        put(32'h134, 32'hAC07_0054);
        do_reset();
        wait_trap(400, seen, tcyc);
        checks++; if (wr_data_q.size() != 6) begin errors++; $display("[TB] FAIL alu_store_count actual=%0d required=6", wr_data_q.size()); end
        for (int k = 0; k < 6; k++) begin
            if (k < wr_data_q.size()) begin
                checks++; if (wr_data_q[k] !== exp_d[k] || wr_addr_q[k] !== exp_a[k]) begin
                    errors++; $display("[TB] FAIL alu_store%0d actual=%h@%h required=%h@%h", k, wr_data_q[k], wr_addr_q[k], exp_d[k], exp_a[k]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        bit seen;
        bit req_seen;
        int tcyc;
        gnt_stall = 0;
        fill_trap();
        do_reset();
        wait_trap(20, seen, tcyc);
        checks++; if (!seen || tcyc != 4) begin errors++; $display("[TB] FAIL illegal_trap_cycle actual=%0d required=4", tcyc); end
        checks++; if (pc_out !== 32'h100) begin errors++; $display("[TB] FAIL illegal_pc actual=%h required=00000100", pc_out); end
        req_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #2;
            if (mem_req !== 1'b0 || trap !== 1'b1) req_seen = 1'b1;
        end
        checks++; if (req_seen) begin errors++; $display("[TB] FAIL illegal_sticky actual=req_or_trap_changed required=req0_trap1"); end
        checks++; if (retire_log.size() != 0 || req_count != 1) begin
            errors++; $display("[TB] FAIL illegal_activity actual=retires%0d_reqs%0d required=retires0_reqs1", retire_log.size(), req_count);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (trap !== 1'b0) begin errors++; $display("[TB] FAIL illegal_reset_clear actual=%0b required=0", trap); end
    endtask

    task automatic test_lw();
        bit seen;
        int tcyc;
        int r0, r1;
        gnt_stall = 0;
        fill_trap();
        put(32'h100, 32'h8C04_0002);
        do_reset();
        wait_trap(20, seen, tcyc);
        checks++; if (!seen || tcyc != 5) begin errors++; $display("[TB] FAIL lw_misalign_trap actual=%0d required=5", tcyc); end
        checks++; if (req_count != 1 || pc_out !== 32'h100) begin
            errors++; $display("[TB] FAIL lw_misalign_state actual=reqs%0d_pc%h required=reqs1_pc00000100", req_count, pc_out);
        end
        fill_trap();
        put(32'h100, 32'h8C04_0008);
        put(32'h104, 32'hAC04_0040);
        put(32'h008, 32'hDEAD_BEEF);
        do_reset();
        wait_trap(40, seen, tcyc);
        r0 = (retire_log.size() > 0) ? retire_log[0] : -1;
        r1 = (retire_log.size() > 1) ? retire_log[1] : -1;
        checks++; if (r0 != 7) begin errors++; $display("[TB] FAIL lw_latency actual=%0d required=7", r0); end
        checks++; if (r1 != 12) begin errors++; $display("[TB] FAIL lw_then_sw_retire actual=%0d required=12", r1); end
        checks++; if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL lw_data actual_count=%0d required=1 write of deadbeef", wr_data_q.size());
        end
        checks++; if (pc_out !== 32'h108) begin errors++; $display("[TB] FAIL lw_trap_pc actual=%h required=00000108", pc_out); end
    endtask

    task automatic test_reset_midreq();
        gnt_stall = 20;
        fill_trap();
        do_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL midreq_pending actual=%0b required=1", mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midreq_async_drop actual=%0b required=0", mem_req); end
        gnt_stall = 0;
    endtask

    initial begin
        $display("[TB] starting mc_mips_core bench");
        test_reset();
        test_program();
        test_gnt_stall();
        test_loop();
        test_alu_ops();
        test_illegal();
        test_lw();
        test_reset_midreq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
